// File: rtl/spi_eeprom_responder_pkg.sv
// Shared opcodes, FSM state encoding and status-register layout for the
// SPI EEPROM responder and the program fetcher that talks to it.
package spi_eeprom_responder_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  localparam int STATUS_WEL_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_STATUS,
    ST_IGNORE
  } state_e;

  function automatic logic [7:0] status_byte(input logic wel);
    logic [7:0] s;
    s = '0;
    s[STATUS_WEL_BIT] = wel;
    return s;
  endfunction

endpackage

// File: rtl/spi_eeprom_responder_if.sv
// SPI wires plus the side preload port, bundled between initiator/harness
// (master) and the EEPROM responder (slave).
interface spi_eeprom_responder_if #(parameter int ADDR_W = 10);
  logic              cs_n;
  logic              copi;
  logic              cipo;
  logic              cipo_oe;
  logic              pl_we;
  logic [ADDR_W-1:0] pl_addr;
  logic [7:0]        pl_data;

  modport master (output cs_n, copi, pl_we, pl_addr, pl_data,
                  input  cipo, cipo_oe);
  modport slave  (input  cs_n, copi, pl_we, pl_addr, pl_data,
                  output cipo, cipo_oe);
endinterface

// File: rtl/spi_eeprom_responder_mem.sv
// Byte array with one write port (preload has priority over SPI writes)
// and an asynchronous read port feeding the CIPO shifter.
module spi_eeprom_mem #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic              pl_we_i,
  input  logic [ADDR_W-1:0] pl_addr_i,
  input  logic [7:0]        pl_data_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0]        mem_q [2**ADDR_W];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  // Preload owns the single write port whenever it strobes.
  always_comb begin
    wr_en   = we_i;
    wr_addr = waddr_i;
    wr_data = wdata_i;
    if (pl_we_i) begin
      wr_en   = 1'b1;
      wr_addr = pl_addr_i;
      wr_data = pl_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/spi_eeprom_responder.sv
// 25xx-style SPI EEPROM target (READ/WRITE/WREN/WRDI/RDSR), SPI mode 0 on clk:
// inputs sampled on the rising edge, CIPO launched on the falling edge.
module spi_eeprom_responder
  import spi_eeprom_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  spi_eeprom_responder_if.slave   bus
);

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shreg_q, shreg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        op_q, op_d;
  logic              wel_q, wel_d;
  logic              armed_q, armed_d;
  logic              cipo_q, cipo_d;
  logic              oe_q, oe_d;

  logic [7:0]        byte_in;
  logic              byte_done;
  logic              mem_we;
  logic [7:0]        rd_data;
  logic [7:0]        stat;

  spi_eeprom_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk       (clk),
    .we_i      (mem_we),
    .waddr_i   (addr_q),
    .wdata_i   (byte_in),
    .pl_we_i   (bus.pl_we),
    .pl_addr_i (bus.pl_addr),
    .pl_data_i (bus.pl_data),
    .raddr_i   (addr_q),
    .rdata_o   (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      wel_q     <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      wel_q     <= wel_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    op_d      = op_q;
    wel_d     = wel_q;
    armed_d   = armed_q;
    mem_we    = 1'b0;
    byte_in   = {shreg_q, bus.copi};
    byte_done = (bit_cnt_q == 3'd7);

    if (bus.cs_n) begin
      // Frame boundary: drop any partial byte; a WRITE frame consumes WEL.
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      armed_d   = 1'b1;
      op_d      = '0;
      if (op_q == OP_WRITE) wel_d = 1'b0;
    end else begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      shreg_d   = byte_in[6:0];
      unique case (state_q)
        // A frame already in progress at reset release is never decoded.
        ST_IDLE:   state_d = armed_q ? ST_CMD : ST_IGNORE;
        ST_CMD: begin
          if (byte_done) begin
            op_d = byte_in;
            unique case (byte_in)
              OP_READ, OP_WRITE: state_d = ST_ADDR_H;
              OP_WREN: begin wel_d = 1'b1; state_d = ST_IGNORE; end
              OP_WRDI: begin wel_d = 1'b0; state_d = ST_IGNORE; end
              OP_RDSR:           state_d = ST_STATUS;
              default:           state_d = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR_H: begin
          addr_d = {addr_q[ADDR_W-2:0], bus.copi};
          if (byte_done) state_d = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          addr_d = {addr_q[ADDR_W-2:0], bus.copi};
          if (byte_done) state_d = (op_q == OP_READ) ? ST_RD_DATA : ST_WR_DATA;
        end
        ST_RD_DATA: begin
          if (byte_done) addr_d = addr_q + ADDR_W'(1);
        end
        ST_WR_DATA: begin
          if (byte_done) begin
            mem_we = wel_q;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
        ST_STATUS: ;
        ST_IGNORE: ;
        default:   state_d = ST_IGNORE;
      endcase
    end
  end

  // bit_cnt_q counts bits already clocked in this byte, so ~bit_cnt_q is
  // the next bit index to present, MSB first.
  always_comb begin
    cipo_d = 1'b0;
    oe_d   = 1'b0;
    stat   = status_byte(wel_q);
    unique case (state_q)
      ST_RD_DATA: begin oe_d = 1'b1; cipo_d = rd_data[~bit_cnt_q]; end
      ST_STATUS:  begin oe_d = 1'b1; cipo_d = stat[~bit_cnt_q];    end
      default: ;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipo_q <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      cipo_q <= cipo_d;
      oe_q   <= oe_d;
    end
  end

  assign bus.cipo    = cipo_q;
  assign bus.cipo_oe = oe_q;

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Directed frames against spi_eeprom_responder; expected CIPO bytes are queued
// as frames are issued and a posedge monitor collects and compares them.
module tb_spi_eeprom_responder;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  logic [7:0] exp_q[$];

  spi_eeprom_responder_if #(.ADDR_W(10)) bus();

  spi_eeprom_responder #(.ADDR_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: the initiator samples CIPO on the rising edge inside a frame.
  initial begin
    logic [7:0] sh;
    logic [7:0] e;
    int nb;
    sh = '0;
    nb = 0;
    forever begin
      @(posedge clk);
      if (!rst_n || bus.cs_n || !bus.cipo_oe) nb = 0;
      else begin
        sh = {sh[6:0], bus.cipo};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_unexpected: got %0h expected no byte", sh);
          end else begin
            e = exp_q.pop_front();
            chk("rx_byte", {24'h0, sh}, {24'h0, e});
          end
        end
      end
    end
  end

  task automatic tx_bit(input logic b);
    @(negedge clk);
    bus.cs_n = 1'b0;
    bus.copi = b;
  endtask

  task automatic tx_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) tx_bit(v[i]);
  endtask

  task automatic end_frame();
    @(negedge clk);
    bus.cs_n = 1'b1;
    bus.copi = 1'b0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.pl_we   = 1'b1;
    bus.pl_addr = a;
    bus.pl_data = d;
    @(negedge clk);
    bus.pl_we   = 1'b0;
  endtask

  task automatic push_exp(input int n, input logic [31:0] exp);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(exp[8*i +: 8]);
  endtask

  task automatic read_frame(input logic [15:0] a, input int n, input logic [31:0] exp);
    push_exp(n, exp);
    tx_byte(8'h03);
    tx_byte(a[15:8]);
    tx_byte(a[7:0]);
    @(posedge clk);
    #1;
    chk("oe_before_data", {31'h0, bus.cipo_oe}, 32'h0);
    chk("cipo_idle_zero", {31'h0, bus.cipo}, 32'h0);
    tx_bit(1'b0);
    #1;
    chk("oe_first_data", {31'h0, bus.cipo_oe}, 32'h1);
    repeat (8 * n - 1) tx_bit(1'b0);
    end_frame();
  endtask

  task automatic write_frame(input logic [15:0] a, input int n, input logic [31:0] d);
    tx_byte(8'h02);
    tx_byte(a[15:8]);
    tx_byte(a[7:0]);
    for (int i = n - 1; i >= 0; i--) tx_byte(d[8*i +: 8]);
    end_frame();
  endtask

  task automatic cmd_frame(input logic [7:0] op);
    tx_byte(op);
    end_frame();
  endtask

  task automatic rdsr_frame(input int n, input logic [31:0] exp);
    push_exp(n, exp);
    tx_byte(8'h05);
    repeat (8 * n) tx_bit(1'b0);
    end_frame();
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.cs_n    = 1'b1;
    bus.copi    = 1'b0;
    bus.pl_we   = 1'b0;
    bus.pl_addr = '0;
    bus.pl_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cipo", {31'h0, bus.cipo}, 32'h0);
    chk("reset_oe", {31'h0, bus.cipo_oe}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic READ streaming four bytes
    preload(10'h000, 8'h00);
    preload(10'h001, 8'h10);
    preload(10'h002, 8'h00);
    preload(10'h003, 8'h20);
    read_frame(16'h0000, 4, 32'h0010_0020);

    // Address wrap at the top of the array, and ignored upper address bits
    preload(10'h3FF, 8'hA5);
    preload(10'h000, 8'h5A);
    read_frame(16'h03FF, 2, 32'h0000_A55A);
    read_frame(16'hFC01, 1, 32'h0000_0010);

    // WRITE without WREN is dropped; with WREN it lands and WEL self-clears
    preload(10'h005, 8'h33);
    write_frame(16'h0005, 1, 32'h77);
    read_frame(16'h0005, 1, 32'h33);
    cmd_frame(8'h06);
    write_frame(16'h0005, 1, 32'h77);
    read_frame(16'h0005, 1, 32'h77);
    rdsr_frame(1, 32'h00);

    // RDSR repeats while selected; WRDI clears WEL
    cmd_frame(8'h06);
    rdsr_frame(2, 32'h0202);
    cmd_frame(8'h04);
    rdsr_frame(1, 32'h00);

    // Partial data byte is discarded; next frame decodes from bit 7
    preload(10'h006, 8'h44);
    cmd_frame(8'h06);
    tx_byte(8'h02);
    tx_byte(8'h00);
    tx_byte(8'h06);
    repeat (4) tx_bit(1'b1);
    end_frame();
    read_frame(16'h0006, 1, 32'h44);
    rdsr_frame(1, 32'h00);

    // Multi-byte write wrapping from 0x3FF to 0x000
    cmd_frame(8'h06);
    write_frame(16'h03FF, 2, 32'h1122);
    read_frame(16'h03FF, 2, 32'h1122);

    // Reset mid-READ with cs_n held low: outputs drop, frame ignored
    exp_q.push_back(8'h11);
    tx_byte(8'h03);
    tx_byte(8'h03);
    tx_byte(8'hFF);
    repeat (11) tx_bit(1'b0);
    #1;
    chk("midread_cipo", {31'h0, bus.cipo}, 32'h1);
    chk("midread_oe", {31'h0, bus.cipo_oe}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_cipo_async", {31'h0, bus.cipo}, 32'h0);
    chk("rst_oe_async", {31'h0, bus.cipo_oe}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_byte(8'h05);
    tx_byte(8'h00);
    #1;
    chk("ignored_after_rst", {31'h0, bus.cipo_oe}, 32'h0);
    end_frame();
    read_frame(16'h03FF, 2, 32'h1122);

    repeat (4) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
